// File: rtl/pipe_phy_status_model_if.sv
// MAC/PHY status signal bundle: MAC-side requests and PHY-side completion status.
interface pipe_phy_status_model_if #(
  parameter int LANESNUMBER = 16
);
  logic [LANESNUMBER-1:0]   TxDetectRx_Loopback;
  logic [LANESNUMBER-1:0]   TxElecIdle;
  logic [4*LANESNUMBER-1:0] PowerDown;
  logic [3:0]               Rate;
  logic [LANESNUMBER-1:0]   PhyStatus;
  logic [3*LANESNUMBER-1:0] RxStatus;
  logic                     busy;

  modport master (
    output TxDetectRx_Loopback, TxElecIdle, PowerDown, Rate,
    input  PhyStatus, RxStatus, busy
  );

  modport slave (
    input  TxDetectRx_Loopback, TxElecIdle, PowerDown, Rate,
    output PhyStatus, RxStatus, busy
  );
endinterface

// File: rtl/pipe_phy_status_model.sv
// Behavioural PHY status responder: answers receiver detect, PowerDown and Rate
// changes with a fixed-latency PhyStatus pulse and per-lane RxStatus codes.
module pipe_phy_status_model #(
  parameter int                     LANESNUMBER    = 16,
  parameter int                     DETECT_LATENCY = 10,
  parameter int                     PD_LATENCY     = 4,
  parameter int                     RATE_LATENCY   = 8,
  parameter logic [LANESNUMBER-1:0] RX_PRESENT     = '1
) (
  input logic                     CLK,
  input logic                     reset,
  pipe_phy_status_model_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DETECT, PD_CHG, RATE_CHG, WAIT_CLR} state_t;

  localparam logic [7:0] DET_LOAD  = 8'(DETECT_LATENCY - 1);
  localparam logic [7:0] PD_LOAD   = 8'(PD_LATENCY - 1);
  localparam logic [7:0] RATE_LOAD = 8'(RATE_LATENCY - 1);
  localparam logic [3:0] PD_P1     = 4'b0010;

  state_t                 state_reg, state_next;
  logic [7:0]             cnt_reg, cnt_next;
  logic [3:0]             prev_pd_reg, prev_pd_next;
  logic [3:0]             prev_rate_reg, prev_rate_next;
  logic [LANESNUMBER-1:0] cap_reg, cap_next;
  logic                   in_reset_reg;
  logic                   pulse, pulse_detect;
  logic [3:0]             pd_cur;
  logic                   detect_req;
  logic                   unused_pd;

  // Only lane 0's PowerDown field steers the model.
  assign pd_cur     = bus.PowerDown[3:0];
  assign unused_pd  = ^bus.PowerDown[4*LANESNUMBER-1:4];
  assign detect_req = (|(bus.TxDetectRx_Loopback & bus.TxElecIdle)) && (pd_cur == PD_P1);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      prev_pd_reg   <= PD_P1;
      prev_rate_reg <= 4'b0000;
      cap_reg       <= '0;
      in_reset_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prev_pd_reg   <= prev_pd_next;
      prev_rate_reg <= prev_rate_next;
      cap_reg       <= cap_next;
      in_reset_reg  <= 1'b0;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    prev_pd_next   = prev_pd_reg;
    prev_rate_next = prev_rate_reg;
    cap_next       = cap_reg;
    pulse          = 1'b0;
    pulse_detect   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Losing events stay pending because their prev register is untouched.
        if (detect_req) begin
          state_next = DETECT;
          cnt_next   = DET_LOAD;
          cap_next   = bus.TxDetectRx_Loopback;
        end else if (pd_cur != prev_pd_reg) begin
          state_next   = PD_CHG;
          cnt_next     = PD_LOAD;
          prev_pd_next = pd_cur;
        end else if (bus.Rate != prev_rate_reg) begin
          state_next     = RATE_CHG;
          cnt_next       = RATE_LOAD;
          prev_rate_next = bus.Rate;
        end
      end
      DETECT: begin
        if (cnt_reg == 8'd0) begin
          pulse        = 1'b1;
          pulse_detect = 1'b1;
          state_next   = WAIT_CLR;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      PD_CHG, RATE_CHG: begin
        if (cnt_reg == 8'd0) begin
          pulse      = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      WAIT_CLR: begin
        if (bus.TxDetectRx_Loopback == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.PhyStatus = in_reset_reg ? '1 : {LANESNUMBER{pulse}};
  assign bus.busy      = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < LANESNUMBER; gi++) begin : g_rxstatus
      assign bus.RxStatus[3*gi +: 3] =
        (pulse_detect && cap_reg[gi] && RX_PRESENT[gi]) ? 3'b011 : 3'b000;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_phy_status_model.sv
// Directed bench: two instances (full and partial receiver-present masks) checked
// every cycle against an event/timestamp model, plus literal latency checks.
module tb_pipe_phy_status_model;
  localparam int L = 16;
  localparam logic [L-1:0] PRES1 = 16'h00FF;
  localparam int DET_LAT  = 10;
  localparam int PD_LAT   = 4;
  localparam int RATE_LAT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [L-1:0]   det, ei;
  logic [4*L-1:0] pd;
  logic [3:0]     rate;

  pipe_phy_status_model_if #(.LANESNUMBER(L)) bus0();
  pipe_phy_status_model_if #(.LANESNUMBER(L)) bus1();

  assign bus0.TxDetectRx_Loopback = det;
  assign bus0.TxElecIdle          = ei;
  assign bus0.PowerDown           = pd;
  assign bus0.Rate                = rate;
  assign bus1.TxDetectRx_Loopback = det;
  assign bus1.TxElecIdle          = ei;
  assign bus1.PowerDown           = pd;
  assign bus1.Rate                = rate;

  pipe_phy_status_model #(.LANESNUMBER(L)) dut0 (.CLK(clk), .reset(reset), .bus(bus0));
  pipe_phy_status_model #(.LANESNUMBER(L), .RX_PRESENT(PRES1)) dut1 (.CLK(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is a pending pulse timestamp; busy spans it plus the detect clear-wait.
  int cyc = 0;
  bit m_valid = 0, m_rst = 0, m_active = 0, m_wait = 0;
  int m_kind = 0, m_at = 0;
  logic [L-1:0] m_cap = '0;
  logic [3:0] m_ppd = 4'b0010, m_prate = 4'b0000;

  always @(negedge clk) begin
    logic [L-1:0]   e_ps;
    logic [3*L-1:0] e_rx0, e_rx1;
    logic           e_busy;
    bit             pulse;
    if (m_valid) begin
      pulse  = !m_rst && m_active && (cyc == m_at);
      e_ps   = (m_rst || pulse) ? '1 : '0;
      e_rx0  = '0;
      e_rx1  = '0;
      if (pulse && m_kind == 1)
        for (int i = 0; i < L; i++) begin
          if (m_cap[i]) e_rx0[3*i +: 3] = 3'b011;
          if (m_cap[i] && PRES1[i]) e_rx1[3*i +: 3] = 3'b011;
        end
      e_busy = !m_rst && (m_active || m_wait);
      check("ps0", 64'(bus0.PhyStatus), 64'(e_ps));
      check("rx0", 64'(bus0.RxStatus), 64'(e_rx0));
      check("busy0", 64'(bus0.busy), 64'(e_busy));
      check("ps1", 64'(bus1.PhyStatus), 64'(e_ps));
      check("rx1", 64'(bus1.RxStatus), 64'(e_rx1));
      check("busy1", 64'(bus1.busy), 64'(e_busy));
    end
    if (reset) begin
      m_valid = 1; m_rst = 1; m_active = 0; m_wait = 0;
      m_ppd = 4'b0010; m_prate = 4'b0000;
    end else if (m_valid) begin
      m_rst = 0;
      if (m_active) begin
        if (cyc == m_at) begin
          m_active = 0;
          m_wait = (m_kind == 1);
        end
      end else if (m_wait) begin
        if (det == '0) m_wait = 0;
      end else if ((det & ei) != '0 && pd[3:0] == 4'b0010) begin
        m_active = 1; m_kind = 1; m_at = cyc + DET_LAT; m_cap = det;
      end else if (pd[3:0] != m_ppd) begin
        m_active = 1; m_kind = 2; m_at = cyc + PD_LAT; m_ppd = pd[3:0];
      end else if (rate != m_prate) begin
        m_active = 1; m_kind = 3; m_at = cyc + RATE_LAT; m_prate = rate;
      end
    end
    cyc++;
  end

  // Cycles from the current one (0) to the next PhyStatus pulse on dut0.
  task automatic measure(input string name, input int exp);
    int lat = 0;
    bit hit = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus0.PhyStatus == '1) begin
        hit = 1;
        break;
      end
      lat++;
    end
    if (!hit) lat = -1;
    check(name, 64'(lat), 64'(exp));
  endtask

  task automatic count_pulses(input string name, input int n);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus0.PhyStatus != '0 || bus1.PhyStatus != '0) cnt++;
    end
    check(name, 64'(cnt), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    det   = '0;
    ei    = '1;
    pd    = {L{4'b0010}};
    rate  = 4'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ps", 64'(bus0.PhyStatus), 64'h0000_0000_0000_FFFF);
    check("rst_busy", 64'(bus0.busy), 64'd0);
    check("rst_rx", 64'(bus0.RxStatus), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rel_ps", 64'(bus0.PhyStatus), 64'd0);
    check("rel_busy", 64'(bus0.busy), 64'd0);

    // Receiver detect in P1 on all lanes.
    @(posedge clk); #1 det = '1;
    measure("det_lat", DET_LAT);
    check("det_rx_all", 64'(bus0.RxStatus), 64'h0000_6DB6_DB6D_B6DB);
    check("det_rx_half", 64'(bus1.RxStatus), 64'h0000_0000_0000_6DB6DB);
    count_pulses("det_no_retrig", 30);
    check("det_wait_busy", 64'(bus0.busy), 64'd1);
    @(posedge clk); #1 det = '0;
    repeat (3) @(negedge clk);
    check("det_clr_busy", 64'(bus0.busy), 64'd0);

    // PowerDown and Rate change together: PowerDown first, Rate after.
    @(posedge clk); #1 begin pd = '0; rate = 4'd1; end
    measure("pd_lat", PD_LAT);
    measure("rate_gap", RATE_LAT);

    // Loopback in P0 gets no response.
    @(posedge clk); #1 det = '1;
    count_pulses("loopback_quiet", 50);
    check("loopback_busy", 64'(bus0.busy), 64'd0);
    @(posedge clk); #1 det = '0;

    @(posedge clk); #1 pd = {L{4'b0010}};
    measure("pd_back_lat", PD_LAT);
    repeat (2) @(negedge clk);

    // Reset three cycles into DETECT aborts the pulse.
    @(posedge clk); #1 det = '1;
    repeat (3) @(posedge clk);
    #1 begin reset = 1'b1; det = '0; rate = 4'd0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    count_pulses("abort_quiet", 15);
    check("abort_busy", 64'(bus0.busy), 64'd0);
    @(posedge clk); #1 det = '1;
    measure("det_after_rst", DET_LAT);
    @(posedge clk); #1 det = '0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_phy_status_model.md
PIPE_PHY_STATUS_MODEL -- requirements
Module: pipe_phy_status_model

Parameters
REQ-001 The block SHALL have parameter LANESNUMBER, default 16, meaning number of PIPE lanes.
REQ-002 The block SHALL have parameter DETECT_LATENCY, default 10, meaning cycles from detect request to PhyStatus pulse (range 1-255).
REQ-003 The block SHALL have parameter PD_LATENCY, default 4, meaning cycles from PowerDown change to PhyStatus pulse (range 1-255).
REQ-004 The block SHALL have parameter RATE_LATENCY, default 8, meaning cycles from Rate change to PhyStatus pulse (range 1-255).
REQ-005 The block SHALL have parameter RX_PRESENT, default all ones, width LANESNUMBER, meaning per-lane receiver-present mask.

Interface
REQ-006 The block SHALL have port CLK, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, meaning reset, which is synchronous and active-high.
REQ-008 The block SHALL have port TxDetectRx_Loopback, input, LANESNUMBER bits, meaning per-lane detect/loopback request from MAC.
REQ-009 The block SHALL have port TxElecIdle, input, LANESNUMBER bits, meaning per-lane transmitter electrical idle.
REQ-010 The block SHALL have port PowerDown, input, 4*LANESNUMBER bits, meaning per-lane power state; the lane 0 field is the controlling value.
REQ-011 The block SHALL have port Rate, input, 4 bits, meaning requested link rate.
REQ-012 The block SHALL have port PhyStatus, output, LANESNUMBER bits, meaning per-lane completion pulse.
REQ-013 The block SHALL have port RxStatus, output, 3*LANESNUMBER bits, meaning per-lane status code, valid while PhyStatus is high.
REQ-014 The block SHALL have port busy, output, 1 bit, meaning an operation is in progress (state not IDLE).

Function
REQ-015 The FSM SHALL have states IDLE, DETECT, PD_CHG, RATE_CHG and WAIT_CLR; one shared counter of 8 bits.
REQ-016 The block SHALL register prev_pd (4 bits) and prev_rate (4 bits), updated only on entry to PD_CHG or RATE_CHG respectively.
REQ-017 In IDLE, a detect request SHALL be: any TxDetectRx_Loopback bit high, TxElecIdle on that lane high, and PowerDown[3:0]==4'b0010 (P1).
REQ-018 TxDetectRx_Loopback high with PowerDown[3:0]==4'b0000 (P0) SHALL be treated as loopback and SHALL produce no response.
REQ-019 In IDLE, a PowerDown event SHALL be PowerDown[3:0]!=prev_pd, and a Rate event SHALL be Rate!=prev_rate.
REQ-020 Simultaneous events SHALL be serviced in the priority order detect > PowerDown > Rate; losing events remain pending because their prev register is unchanged.
REQ-021 In DETECT, PD_CHG and RATE_CHG, the counter SHALL load the latency-1 value on entry and decrement each cycle; the pulse occurs on the cycle the counter reaches 0.
REQ-022 Total latency SHALL be exactly DETECT_LATENCY, PD_LATENCY or RATE_LATENCY cycles, measured from the IDLE cycle that sees the event to the cycle PhyStatus is high.
REQ-023 The detect pulse SHALL drive PhyStatus all ones for one cycle; each lane's RxStatus is 3'b011 if that lane's request bit and RX_PRESENT bit are both set, else 3'b000.
REQ-024 After a detect pulse, the FSM SHALL enter WAIT_CLR and remain there until all TxDetectRx_Loopback bits are low, then return to IDLE.
REQ-025 PD_CHG and RATE_CHG pulses SHALL drive PhyStatus all ones for one cycle with RxStatus all 3'b000, then return to IDLE.
REQ-026 In all other cycles, PhyStatus and RxStatus SHALL be 0.
REQ-027 Input changes during a non-IDLE state SHALL NOT abort the operation; they are evaluated on return to IDLE.
REQ-028 Deassertion of a detect request mid-DETECT SHALL NOT cancel the pulse; RxStatus uses the request bits captured on DETECT entry.

Reset
REQ-029 While reset is high: state=IDLE, counter=0, PhyStatus=all ones, RxStatus=0, busy=0, prev_pd=4'b0010, prev_rate=4'b0000.
REQ-030 PhyStatus SHALL fall to 0 on the first rising edge with reset low.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no further pulse, and the next cycle SHALL show the REQ-029 values.

Verification
REQ-032 Reset for 2 cycles then release -> PhyStatus=16'hFFFF during reset, 16'h0000 on the first cycle after release, busy=0.
REQ-033 PowerDown=P1, TxElecIdle=all ones, TxDetectRx_Loopback=16'hFFFF -> exactly 10 cycles later PhyStatus=16'hFFFF for 1 cycle and RxStatus=16 copies of 3'b011; no retrigger until the request is deasserted.
REQ-034 RX_PRESENT=16'h00FF, same stimulus as REQ-033 -> lanes 0-7 show 3'b011 and lanes 8-15 show 3'b000 on the pulse cycle.
REQ-035 PowerDown P1->P0 and Rate 0->1 in the same cycle -> PhyStatus pulse 4 cycles later (PowerDown), then IDLE, then a second pulse 8 cycles after re-entering IDLE (Rate).
REQ-036 PowerDown=P0 with TxDetectRx_Loopback=16'hFFFF (loopback) -> no PhyStatus pulse for 50 cycles.
REQ-037 Reset asserted 3 cycles into DETECT -> no pulse; after release busy=0 and a new request yields a full 10-cycle latency.
